// File: rtl/fetch_exec_controller_pkg.sv
// Shared types and encodings for the fetch/decode/execute controller of the
// Simple RISC Machine: state enum, instruction fields, mux selects, memory commands.
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RST,
    S_IF1,
    S_IF2,
    S_UPDATE_PC,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_ALU_MOV,
    S_CMP,
    S_WRITE_REG,
    S_WRITE_IMM,
    S_ADDR,
    S_LOAD_ADDR,
    S_MEM_RD1,
    S_MEM_RD2,
    S_GET_RD,
    S_MEM_WR,
    S_HALT
  } state_t;

  // instreg[15:13]
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // instreg[12:11]
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_NONE    = 2'b00;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef struct packed {
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic [2:0] nsel;
    logic       write;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       load_addr;
    logic       addr_sel;
    logic [1:0] mem_cmd;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/fetch_exec_controller_if.sv
// Control bundle between the sequencing FSM (master) and the datapath/PC/IR/memory (slave).
interface fetch_exec_controller_if;
  import cpu_ctrl_pkg::*;

  // No valid/ready pair here: memory has a fixed one-cycle read latency, so a
  // READ held for two consecutive cycles always yields mdata in the second, and
  // a WRITE held for one cycle always completes.
  logic [2:0] opcode;
  logic [1:0] op;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic [1:0] vsel;
  logic [2:0] nsel;
  logic       write;
  logic       load_ir;
  logic       load_pc;
  logic       reset_pc;
  logic       load_addr;
  logic       addr_sel;
  logic [1:0] mem_cmd;
  logic       halted;
  state_t     state;

  modport master (
    input  opcode, op,
    output loada, loadb, loadc, loads, asel, bsel, vsel, nsel, write,
    output load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd, halted,
    output state
  );

  modport slave (
    output opcode, op,
    input  loada, loadb, loadc, loads, asel, bsel, vsel, nsel, write,
    input  load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd, halted,
    input  state
  );

endinterface

// File: rtl/fetch_exec_controller.sv
// Moore FSM running the autonomous fetch/decode/execute loop. Outputs depend on
// state only; opcode/op come from the IR, which is stable from UPDATE_PC onward.
module fetch_exec_controller
  import cpu_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALTS = 1'b1
) (
  input logic                      clk,
  input logic                      reset,
  fetch_exec_controller_if.master  ctl
);

  state_t state;
  state_t state_n;
  ctrl_t  c;

  always_ff @(posedge clk) begin
    if (reset) state <= S_RST;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    c       = CTRL_IDLE;
    case (state)
      S_RST: begin
        c.reset_pc = 1'b1;
        c.load_pc  = 1'b1;
        state_n    = S_IF1;
      end
      S_IF1: begin
        c.addr_sel = 1'b1;
        c.mem_cmd  = MEM_READ;
        state_n    = S_IF2;
      end
      S_IF2: begin
        c.addr_sel = 1'b1;
        c.mem_cmd  = MEM_READ;
        c.load_ir  = 1'b1;
        state_n    = S_UPDATE_PC;
      end
      S_UPDATE_PC: begin
        c.load_pc = 1'b1;
        state_n   = S_DECODE;
      end
      S_DECODE: begin
        case ({ctl.opcode, ctl.op})
          {OPC_MOV, OP_MOV_IMM}: state_n = S_WRITE_IMM;
          {OPC_MOV, OP_MOV_REG}: state_n = S_GET_B;
          {OPC_ALU, OP_ADD},
          {OPC_ALU, OP_AND},
          {OPC_ALU, OP_CMP}:     state_n = S_GET_A;
          {OPC_ALU, OP_MVN}:     state_n = S_GET_B;
          {OPC_LDR, OP_NONE},
          {OPC_STR, OP_NONE}:    state_n = S_GET_A;
          {OPC_HALT, OP_NONE}:   state_n = S_HALT;
          default:               state_n = ILLEGAL_HALTS ? S_HALT : S_IF1;
        endcase
      end
      S_GET_A: begin
        c.nsel  = NSEL_RN;
        c.loada = 1'b1;
        // Two-operand ALU ops continue to Rm; LDR/STR compute Rn+sximm5.
        state_n = (ctl.opcode == OPC_ALU) ? S_GET_B : S_ADDR;
      end
      S_GET_B: begin
        c.nsel  = NSEL_RM;
        c.loadb = 1'b1;
        if (ctl.opcode == OPC_MOV)   state_n = S_ALU_MOV;
        else if (ctl.op == OP_CMP)   state_n = S_CMP;
        else                         state_n = S_ALU;
      end
      S_ALU: begin
        c.loadc = 1'b1;
        state_n = S_WRITE_REG;
      end
      S_ALU_MOV: begin
        c.asel  = 1'b1;
        c.loadc = 1'b1;
        // Shared by MOV reg and by STR, which passes Rd through C to the bus.
        state_n = (ctl.opcode == OPC_STR) ? S_MEM_WR : S_WRITE_REG;
      end
      S_CMP: begin
        c.loads = 1'b1;
        state_n = S_IF1;
      end
      S_WRITE_REG: begin
        c.nsel  = NSEL_RD;
        c.vsel  = VSEL_C;
        c.write = 1'b1;
        state_n = S_IF1;
      end
      S_WRITE_IMM: begin
        c.nsel  = NSEL_RN;
        c.vsel  = VSEL_IMM;
        c.write = 1'b1;
        state_n = S_IF1;
      end
      S_ADDR: begin
        c.bsel  = 1'b1;
        c.loadc = 1'b1;
        state_n = S_LOAD_ADDR;
      end
      S_LOAD_ADDR: begin
        c.load_addr = 1'b1;
        state_n     = (ctl.opcode == OPC_LDR) ? S_MEM_RD1 : S_GET_RD;
      end
      S_MEM_RD1: begin
        c.mem_cmd = MEM_READ;
        state_n   = S_MEM_RD2;
      end
      S_MEM_RD2: begin
        c.mem_cmd = MEM_READ;
        c.nsel    = NSEL_RD;
        c.vsel    = VSEL_MDATA;
        c.write   = 1'b1;
        state_n   = S_IF1;
      end
      S_GET_RD: begin
        c.nsel  = NSEL_RD;
        c.loadb = 1'b1;
        state_n = S_ALU_MOV;
      end
      S_MEM_WR: begin
        c.mem_cmd = MEM_WRITE;
        state_n   = S_IF1;
      end
      S_HALT: begin
        c.halted = 1'b1;
        state_n  = S_HALT;
      end
      default: state_n = S_RST;
    endcase
  end

  assign ctl.loada     = c.loada;
  assign ctl.loadb     = c.loadb;
  assign ctl.loadc     = c.loadc;
  assign ctl.loads     = c.loads;
  assign ctl.asel      = c.asel;
  assign ctl.bsel      = c.bsel;
  assign ctl.vsel      = c.vsel;
  assign ctl.nsel      = c.nsel;
  assign ctl.write     = c.write;
  assign ctl.load_ir   = c.load_ir;
  assign ctl.load_pc   = c.load_pc;
  assign ctl.reset_pc  = c.reset_pc;
  assign ctl.load_addr = c.load_addr;
  assign ctl.addr_sel  = c.addr_sel;
  assign ctl.mem_cmd   = c.mem_cmd;
  assign ctl.halted    = c.halted;
  assign ctl.state     = state;

endmodule
